// File: rtl/in_port_fifo_rd.sv
// in_port_fifo_rd
//   CPU-side input port. It captures bytes strobed in by an asynchronous
//   peripheral into a small FIFO. The head byte and the status flags are
//   presented to the bus I/O read mux, and each completed CPU read pops one
//   byte.
//
// Ports
//   clock    : system clock; all state changes on the rising edge
//   reset_n  : asynchronous active-low reset
//   pStrobe  : async peripheral strobe; a rising edge means a new byte on pData
//   pData    : peripheral data, stable until the synchronised edge is used
//   cpuRd    : synchronous level, high for the whole CPU data-port read
//   clrOvr   : synchronous pulse that clears overrun
//   dataOut  : registered show-ahead head byte; 0 when the FIFO is empty
//   ready    : FIFO is not empty
//   full     : FIFO holds DEPTH entries
//   overrun  : sticky flag; a byte was dropped because the FIFO was full
//   count    : occupancy
module in_port_fifo_rd #(
  parameter int N           = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     pStrobe,
  input  logic [N-1:0]             pData,
  input  logic                     cpuRd,
  input  logic                     clrOvr,
  output logic [N-1:0]             dataOut,
  output logic                     ready,
  output logic                     full,
  output logic                     overrun,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [SYNC_STAGES-1:0] sync;
  logic                   hist;
  logic                   rdPrev;
  logic                   rdActive;
  logic [PW-1:0]          rdPtr;
  logic [PW-1:0]          wrPtr;
  logic [N-1:0]           mem [DEPTH];

  logic                   wrEvt;
  logic                   rdRise;
  logic                   rdFall;
  logic                   pop;
  logic                   wrAcc;
  logic [PW-1:0]          rdPtrNext;
  logic [PW-1:0]          wrPtrNext;
  logic [CW-1:0]          countNext;
  logic                   rdActiveNext;
  logic                   overrunNext;
  logic [N-1:0]           headNext;
  logic [N-1:0]           dataOutNext;

  // The sync chain and edge history reset high. A strobe that is already
  // high when reset is released therefore never looks like a rising edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync   <= '1;
      hist   <= 1'b1;
      rdPrev <= 1'b0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], pStrobe};
      hist   <= sync[SYNC_STAGES-1];
      rdPrev <= cpuRd;
    end
  end

  always_comb begin
    wrEvt  = sync[SYNC_STAGES-1] & ~hist;
    rdRise = cpuRd & ~rdPrev;
    rdFall = ~cpuRd & rdPrev;
    pop    = rdFall & rdActive;
    // A full FIFO still accepts a byte when a pop frees a slot in the same clock.
    wrAcc  = wrEvt & ((count != FULL_CNT) | pop);

    rdPtrNext = pop   ? rdPtr + 1'b1 : rdPtr;
    wrPtrNext = wrAcc ? wrPtr + 1'b1 : wrPtr;

    countNext = count;
    case ({wrAcc, pop})
      2'b10:   countNext = count + 1'b1;
      2'b01:   countNext = count - 1'b1;
      default: countNext = count;
    endcase

    rdActiveNext = rdActive;
    if (rdRise)
      rdActiveNext = ready;
    else if (pop)
      rdActiveNext = 1'b0;

    overrunNext = overrun;
    if (wrEvt && !wrAcc)
      overrunNext = 1'b1;
    else if (clrOvr)
      overrunNext = 1'b0;

    // The next head comes from the incoming byte when that byte lands in the
    // head slot. This happens on a write into an empty FIFO, or on a
    // write+pop that leaves exactly one entry.
    headNext = '0;
    if (countNext != '0) begin
      if (wrAcc && (wrPtr == rdPtrNext))
        headNext = pData;
      else
        headNext = mem[rdPtrNext];
    end

    // dataOut is frozen for the whole read cycle, and catches up afterwards.
    dataOutNext = cpuRd ? dataOut : headNext;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rdPtr    <= '0;
      wrPtr    <= '0;
      count    <= '0;
      rdActive <= 1'b0;
      overrun  <= 1'b0;
      dataOut  <= '0;
    end else begin
      rdPtr    <= rdPtrNext;
      wrPtr    <= wrPtrNext;
      count    <= countNext;
      rdActive <= rdActiveNext;
      overrun  <= overrunNext;
      dataOut  <= dataOutNext;
    end
  end

  always_ff @(posedge clock) begin
    if (wrAcc)
      mem[wrPtr] <= pData;
  end

  always_comb begin
    ready = (count != '0);
    full  = (count == FULL_CNT);
  end

endmodule

// File: tb/tb_in_port_fifo_rd.sv
module tb_in_port_fifo_rd;

  logic       clock;
  logic       reset_n;
  logic       pStrobe;
  logic [7:0] pData;
  logic       cpuRd;
  logic       clrOvr;
  logic [7:0] dataOut;
  logic       ready;
  logic       full;
  logic       overrun;
  logic [2:0] count;

  int tests;
  int fails;

  logic [7:0] mq[$];  // model of FIFO contents
  logic [7:0] sb[$];  // expected dataOut for each issued read
  logic       inRead;

  in_port_fifo_rd #(
    .N(8),
    .DEPTH(4),
    .SYNC_STAGES(2)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .pStrobe(pStrobe),
    .pData(pData),
    .cpuRd(cpuRd),
    .clrOvr(clrOvr),
    .dataOut(dataOut),
    .ready(ready),
    .full(full),
    .overrun(overrun),
    .count(count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: it checks dataOut against the scoreboard head on every clock of
  // a read, and retires the entry when the read ends.
  initial inRead = 1'b0;
  always @(posedge clock) begin
    #1;
    if (!reset_n) begin
      sb.delete();
      inRead = 1'b0;
    end else if (cpuRd) begin
      if (!inRead && sb.size() > 0) inRead = 1'b1;
      if (inRead) chk("rd_data", 32'(dataOut), 32'(sb[0]));
    end else if (inRead) begin
      void'(sb.pop_front());
      inRead = 1'b0;
    end
  end

  task automatic push(input logic [7:0] b);
    pData   = b;
    pStrobe = 1'b1;
    if (mq.size() < 4) mq.push_back(b);
    repeat (4) @(negedge clock);
    pStrobe = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  task automatic rd();
    logic [7:0] e;
    e = 8'h00;
    if (mq.size() > 0) e = mq.pop_front();
    cpuRd = 1'b1;
    sb.push_back(e);
    repeat (2) @(negedge clock);
    cpuRd = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tests = 0; fails = 0;
    reset_n = 1'b0; pStrobe = 1'b0; pData = 8'h00; cpuRd = 1'b0; clrOvr = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_count", 32'(count), 0);
    chk("rst_ready", 32'(ready), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_ovr", 32'(overrun), 0);
    chk("rst_data", 32'(dataOut), 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);

    // T1: latency of the first write
    pData = 8'hA5; pStrobe = 1'b1; mq.push_back(8'hA5);
    repeat (2) @(negedge clock);
    chk("t1_ready_early", 32'(ready), 0);
    @(negedge clock);
    chk("t1_ready", 32'(ready), 1);
    chk("t1_count", 32'(count), 1);
    chk("t1_data", 32'(dataOut), 32'hA5);
    @(negedge clock);
    pStrobe = 1'b0;
    repeat (3) @(negedge clock);
    rd();
    chk("t1_empty_count", 32'(count), 0);
    chk("t1_empty_data", 32'(dataOut), 0);

    // T2: fill, overflow, drain
    push(8'h11); push(8'h22); push(8'h33); push(8'h44); push(8'h55);
    chk("t2_full", 32'(full), 1);
    chk("t2_ovr", 32'(overrun), 1);
    chk("t2_count", 32'(count), 4);
    chk("t2_head", 32'(dataOut), 32'h11);
    repeat (4) rd();
    chk("t2_ready", 32'(ready), 0);
    chk("t2_data0", 32'(dataOut), 0);
    chk("t2_nfull", 32'(full), 0);
    clrOvr = 1'b1;
    @(negedge clock);
    clrOvr = 1'b0;
    chk("t2_ovr_clr", 32'(overrun), 0);

    // T3: write event on the pop clock while full
    push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4);
    chk("t3_full", 32'(full), 1);
    pData = 8'hB5; pStrobe = 1'b1; cpuRd = 1'b1;
    sb.push_back(mq.pop_front());
    mq.push_back(8'hB5);
    repeat (2) @(negedge clock);
    cpuRd = 1'b0;
    @(negedge clock);
    chk("t3_count", 32'(count), 4);
    chk("t3_ovr", 32'(overrun), 0);
    chk("t3_head", 32'(dataOut), 32'hA2);
    chk("t3_full2", 32'(full), 1);
    @(negedge clock);
    pStrobe = 1'b0;
    repeat (3) @(negedge clock);
    repeat (4) rd();
    chk("t3_drained", 32'(count), 0);

    // T4: a read started empty, with a byte arriving mid-read
    cpuRd = 1'b1;
    sb.push_back(8'h00);
    @(negedge clock);
    push(8'h77);
    cpuRd = 1'b0;
    repeat (2) @(negedge clock);
    chk("t4_count", 32'(count), 1);
    chk("t4_ready", 32'(ready), 1);
    chk("t4_data", 32'(dataOut), 32'h77);
    rd();
    chk("t4_count0", 32'(count), 0);

    // T5: strobe high through reset release; clrOvr against a drop
    pStrobe = 1'b1; reset_n = 1'b0;
    mq.delete();
    @(negedge clock);
    reset_n = 1'b1;
    repeat (5) @(negedge clock);
    chk("t5_nowrite", 32'(count), 0);
    chk("t5_noready", 32'(ready), 0);
    pStrobe = 1'b0;
    repeat (3) @(negedge clock);
    push(8'h66);
    chk("t5_count1", 32'(count), 1);
    chk("t5_data", 32'(dataOut), 32'h66);
    push(8'h67); push(8'h68); push(8'h69);
    pData = 8'h6A; pStrobe = 1'b1;
    repeat (2) @(negedge clock);
    clrOvr = 1'b1;
    @(negedge clock);
    clrOvr = 1'b0;
    chk("t5_set_wins", 32'(overrun), 1);
    chk("t5_count4", 32'(count), 4);
    @(negedge clock);
    pStrobe = 1'b0;
    repeat (3) @(negedge clock);
    chk("t5_sticky", 32'(overrun), 1);
    clrOvr = 1'b1;
    @(negedge clock);
    clrOvr = 1'b0;
    chk("t5_clr", 32'(overrun), 0);

    // T6: reset in the middle of a read
    rd();
    chk("t6_count3", 32'(count), 3);
    cpuRd = 1'b1;
    sb.push_back(mq[0]);
    repeat (2) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_count", 32'(count), 0);
    chk("t6_ready", 32'(ready), 0);
    chk("t6_data", 32'(dataOut), 0);
    chk("t6_full", 32'(full), 0);
    mq.delete();
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    cpuRd = 1'b0;
    repeat (2) @(negedge clock);
    chk("t6_nopop", 32'(count), 0);
    push(8'h88);
    chk("t6_count1", 32'(count), 1);
    rd();
    chk("t6_count0", 32'(count), 0);
    chk("sb_drained", 32'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
